// File: rtl/mem_resp_queue.sv
// In-order tracker for accepted LSU requests: pairs dcache responses in issue order and hands
// completed results to writeback. Define MEM_RESP_BYPASS_EN for a zero-latency head bypass.
module mem_resp_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_fire,
    input  logic             req_is_load,
    input  logic [4:0]       req_rd,
    input  logic [31:0]      req_pc,
    output logic             can_issue,
    input  logic             lsu_ok,
    input  logic [31:0]      lsu_ld_data,
    input  logic             flush,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_pc,
    output logic [31:0]      wb_data,
    output logic             busy,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] is_load_q;
    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] killed_q;
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic [PTR_W:0]   alloc_q;
    logic [PTR_W:0]   resp_q;
    logic [PTR_W:0]   head_q;
    logic [PTR_W-1:0] alloc_idx;
    logic [PTR_W-1:0] resp_idx;
    logic [PTR_W-1:0] head_idx;

    logic occupied;
    logic head_done;
    logic head_killed;
    logic bypass;
    logic retire;

    assign alloc_idx = alloc_q[PTR_W-1:0];
    assign resp_idx  = resp_q[PTR_W-1:0];
    assign head_idx  = head_q[PTR_W-1:0];

    assign count     = alloc_q - head_q;
    assign occupied  = (count != '0);
    assign busy      = occupied;
    assign can_issue = (count != FULL_COUNT);

    assign head_done   = done_q[head_idx];
    assign head_killed = killed_q[head_idx];

`ifdef MEM_RESP_BYPASS_EN
    assign bypass = lsu_ok && (resp_q == head_q) && occupied && !head_killed && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign wb_valid = (head_done && !head_killed && occupied && !flush) || bypass;
    assign wb_we    = is_load_q[head_idx];
    assign wb_rd    = rd_q[head_idx];
    assign wb_pc    = pc_q[head_idx];
    assign wb_data  = !is_load_q[head_idx] ? 32'h0 :
                      bypass               ? lsu_ld_data : data_q[head_idx];

    // Killed entries drain one per cycle once their response has been consumed.
    assign retire = (wb_valid && wb_ready) || (occupied && head_done && head_killed);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alloc_q   <= '0;
            resp_q    <= '0;
            head_q    <= '0;
            is_load_q <= '0;
            done_q    <= '0;
            killed_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            // Free slots get killed too; allocation rewrites the flag anyway.
            if (flush) begin
                killed_q <= '1;
            end
            if (lsu_ok) begin
                data_q[resp_idx] <= lsu_ld_data;
                done_q[resp_idx] <= 1'b1;
                resp_q           <= resp_q + 1'b1;
            end
            if (req_fire) begin
                is_load_q[alloc_idx] <= req_is_load;
                rd_q[alloc_idx]      <= req_rd;
                pc_q[alloc_idx]      <= req_pc;
                done_q[alloc_idx]    <= 1'b0;
                killed_q[alloc_idx]  <= flush;
                alloc_q              <= alloc_q + 1'b1;
            end
            if (retire) begin
                head_q <= head_q + 1'b1;
            end
        end
    end

    a_no_issue_when_full : assert property (
        @(posedge clk) disable iff (!reset) req_fire |-> can_issue);
    a_no_orphan_response : assert property (
        @(posedge clk) disable iff (!reset) lsu_ok |-> (resp_q != alloc_q));

endmodule

// File: tb/tb_mem_resp_queue.sv
// Self-checking bench for mem_resp_queue: directed scenarios plus a randomized run against a
// queue-based reference model. Honours MEM_RESP_BYPASS_EN when the design is built with it.
module tb_mem_resp_queue;

    localparam int DEPTH = 4;
`ifdef MEM_RESP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_fire;
    logic        req_is_load;
    logic [4:0]  req_rd;
    logic [31:0] req_pc;
    logic        can_issue;
    logic        lsu_ok;
    logic [31:0] lsu_ld_data;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_pc;
    logic [31:0] wb_data;
    logic        busy;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    mem_resp_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_fire    (req_fire),
        .req_is_load (req_is_load),
        .req_rd      (req_rd),
        .req_pc      (req_pc),
        .can_issue   (can_issue),
        .lsu_ok      (lsu_ok),
        .lsu_ld_data (lsu_ld_data),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_pc       (wb_pc),
        .wb_data     (wb_data),
        .busy        (busy),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rise.
    task automatic drive(input logic fire, input logic ld, input logic [4:0] rd,
                         input logic [31:0] pc, input logic ok, input logic [31:0] d,
                         input logic fl, input logic rdy);
        @(negedge clk);
        req_fire    = fire;
        req_is_load = ld;
        req_rd      = rd;
        req_pc      = pc;
        lsu_ok      = ok;
        lsu_ld_data = d;
        flush       = fl;
        wb_ready    = rdy;
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, rdy);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_fire = 1'b0; req_is_load = 1'b0; req_rd = '0; req_pc = '0;
        lsu_ok = 1'b0; lsu_ld_data = '0; flush = 1'b0; wb_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({wb_valid, wb_we, busy, can_issue, count, wb_rd, wb_pc, wb_data} !==
            {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 5'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b we=%b busy=%b ci=%b cnt=%0d rd=%0d pc=%h d=%h",
                     wb_valid, wb_we, busy, can_issue, count, wb_rd, wb_pc, wb_data);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_load();
        drive(1'b1, 1'b1, 5'd3, 32'h1c000010, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(1'b0);
        checks++;
        if ({count, busy, wb_valid} !== {3'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_pending: got cnt=%0d busy=%b v=%b exp cnt=1 busy=1 v=0",
                     count, busy, wb_valid);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'hdeadbeef, 1'b0, 1'b0);
        checks++;
        if (wb_valid !== BYP) begin
            errors++;
            $display("FAIL single_resp_cycle: got v=%b exp v=%b", wb_valid, BYP);
        end
        idle(1'b1);
        checks++;
        if ({wb_valid, wb_we, wb_rd, wb_pc, wb_data} !==
            {1'b1, 1'b1, 5'd3, 32'h1c000010, 32'hdeadbeef}) begin
            errors++;
            $display("FAIL single_wb: got v=%b we=%b rd=%0d pc=%h d=%h exp 1 1 3 1c000010 deadbeef",
                     wb_valid, wb_we, wb_rd, wb_pc, wb_data);
        end
        idle(1'b0);
        checks++;
        if ({count, busy} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL single_empty: got cnt=%0d busy=%b exp 0 0", count, busy);
        end
    endtask

    task automatic test_full_wrap();
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < DEPTH; i++) begin
                drive(1'b1, 1'b1, 5'(w * 4 + i + 1), 32'h1c000100 + 32'(4 * (w * 4 + i)),
                      1'b0, 32'h0, 1'b0, 1'b0);
            end
            idle(1'b0);
            checks++;
            if ({count, can_issue} !== {3'd4, 1'b0}) begin
                errors++;
                $display("FAIL full_count: got cnt=%0d ci=%b exp 4 0", count, can_issue);
            end
            for (int i = 0; i < DEPTH; i++) begin
                drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'(w * 4 + i), 1'b0, 1'b0);
            end
            for (int i = 0; i < DEPTH; i++) begin
                idle(1'b1);
                checks++;
                if ({count, can_issue, wb_valid, wb_rd, wb_data} !==
                    {3'(4 - i), (i != 0), 1'b1, 5'(w * 4 + i + 1), 32'(w * 4 + i)}) begin
                    errors++;
                    $display("FAIL full_retire: got cnt=%0d ci=%b v=%b rd=%0d d=%0d exp %0d %b 1 %0d %0d",
                             count, can_issue, wb_valid, wb_rd, wb_data,
                             4 - i, (i != 0), w * 4 + i + 1, w * 4 + i);
                end
            end
            idle(1'b0);
            checks++;
            if (count !== 3'd0) begin
                errors++;
                $display("FAIL full_drained: got cnt=%0d exp 0", count);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d1, d2;
        d1 = $urandom;
        d2 = $urandom;
        drive(1'b1, 1'b1, 5'd1, 32'h1c000200, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 5'd2, 32'h1c000204, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, d1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, d2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            checks++;
            if ({wb_valid, wb_rd, wb_pc, wb_data} !== {1'b1, 5'd1, 32'h1c000200, d1}) begin
                errors++;
                $display("FAIL bp_hold: got v=%b rd=%0d pc=%h d=%h exp 1 1 1c000200 %h",
                         wb_valid, wb_rd, wb_pc, wb_data, d1);
            end
        end
        idle(1'b1);
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd1, d1}) begin
            errors++;
            $display("FAIL bp_first: got v=%b rd=%0d d=%h exp 1 1 %h", wb_valid, wb_rd, wb_data, d1);
        end
        idle(1'b1);
        checks++;
        if ({wb_valid, wb_rd, wb_pc, wb_data} !== {1'b1, 5'd2, 32'h1c000204, d2}) begin
            errors++;
            $display("FAIL bp_second: got v=%b rd=%0d pc=%h d=%h exp 1 2 1c000204 %h",
                     wb_valid, wb_rd, wb_pc, wb_data, d2);
        end
        idle(1'b0);
        checks++;
        if ({count, wb_valid} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL bp_empty: got cnt=%0d v=%b exp 0 0", count, wb_valid);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 5'd4, 32'h1c000300, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 5'd5, 32'h1c000304, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 5'd6, 32'h1c000308, 1'b0, 32'h0, 1'b1, 1'b1);
        idle(1'b1);
        checks++;
        if ({count, wb_valid} !== {3'd3, 1'b0}) begin
            errors++;
            $display("FAIL flush_count: got cnt=%0d v=%b exp 3 0", count, wb_valid);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, $urandom, 1'b0, 1'b1);
            checks++;
            if (wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_wb: got v=%b exp 0 (response %0d)", wb_valid, i);
            end
        end
        idle(1'b1);
        idle(1'b1);
        checks++;
        if ({count, wb_valid} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL flush_drained: got cnt=%0d v=%b exp 0 0", count, wb_valid);
        end
        // A head that is already valid must be dropped by the flush.
        drive(1'b1, 1'b1, 5'd8, 32'h1c000310, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h55aa55aa, 1'b0, 1'b0);
        idle(1'b0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid_head: got v=%b exp 0", wb_valid);
        end
        idle(1'b1);
        idle(1'b1);
        checks++;
        if ({count, wb_valid} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL flush_head_drained: got cnt=%0d v=%b exp 0 0", count, wb_valid);
        end
    endtask

    task automatic test_store();
        drive(1'b1, 1'b0, 5'd0, 32'h1c000020, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(1'b0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h12345678, 1'b0, 1'b0);
        checks++;
        if ({wb_valid, wb_we} !== {BYP, 1'b0}) begin
            errors++;
            $display("FAIL store_resp_cycle: got v=%b we=%b exp %b 0", wb_valid, wb_we, BYP);
        end
        idle(1'b1);
        checks++;
        if ({wb_valid, wb_we, wb_rd, wb_pc, wb_data} !==
            {1'b1, 1'b0, 5'd0, 32'h1c000020, 32'h0}) begin
            errors++;
            $display("FAIL store_wb: got v=%b we=%b rd=%0d pc=%h d=%h exp 1 0 0 1c000020 0",
                     wb_valid, wb_we, wb_rd, wb_pc, wb_data);
        end
        idle(1'b0);
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL store_empty: got cnt=%0d exp 0", count);
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b1, 5'd9, 32'h1c000400, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(1'b1);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'hcafef00d, 1'b0, 1'b1);
        checks++;
        if ({wb_valid, (wb_valid ? wb_data : 32'h0)} !== {BYP, (BYP ? 32'hcafef00d : 32'h0)}) begin
            errors++;
            $display("FAIL bypass_same_cycle: got v=%b d=%h exp v=%b", wb_valid, wb_data, BYP);
        end
        idle(1'b1);
        checks++;
        if ({count, wb_valid} !== {(BYP ? 3'd0 : 3'd1), !BYP}) begin
            errors++;
            $display("FAIL bypass_next_cycle: got cnt=%0d v=%b exp cnt=%0d v=%b",
                     count, wb_valid, BYP ? 0 : 1, !BYP);
        end
        idle(1'b0);
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL bypass_empty: got cnt=%0d exp 0", count);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 5'(10 + i), 32'h1c000500 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0badf00d, 1'b0, 1'b0);
        idle(1'b0);
        checks++;
        if ({count, wb_valid} !== {3'd3, 1'b1}) begin
            errors++;
            $display("FAIL areset_setup: got cnt=%0d v=%b exp 3 1", count, wb_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({wb_valid, wb_we, busy, can_issue, count, wb_rd, wb_pc, wb_data} !==
            {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 5'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL areset_outputs: got v=%b we=%b busy=%b ci=%b cnt=%0d rd=%0d pc=%h d=%h",
                     wb_valid, wb_we, busy, can_issue, count, wb_rd, wb_pc, wb_data);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic        ld;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] data;
        bit          killed;
    } ent_t;

    task automatic test_random();
        ent_t        q[$];
        int          ndone = 0;
        logic        fire, ld, ok, fl, rdy;
        logic [4:0]  rd;
        logic [31:0] pc, d, exp_data;
        bit          head_done, exp_byp, exp_valid, do_retire;
        for (int cyc = 0; cyc < 600; cyc++) begin
            fire = (q.size() < DEPTH) && ($urandom_range(0, 99) < 60);
            ok   = (ndone < q.size()) && ($urandom_range(0, 99) < 50);
            fl   = ($urandom_range(0, 99) < 4);
            rdy  = ($urandom_range(0, 99) < 70);
            ld   = 1'($urandom);
            rd   = 5'($urandom);
            pc   = $urandom;
            d    = $urandom;
            drive(fire, ld, rd, pc, ok, d, fl, rdy);

            head_done = (q.size() > 0) && (ndone > 0);
            exp_byp   = BYP && ok && (ndone == 0) && !q[0].killed && !fl;
            exp_valid = (head_done && !q[0].killed && !fl) || exp_byp;
            checks++;
            if ({count, busy, can_issue, wb_valid} !==
                {3'(q.size()), (q.size() != 0), (q.size() != DEPTH), exp_valid}) begin
                errors++;
                $display("FAIL rand_status cyc %0d: got cnt=%0d busy=%b ci=%b v=%b exp cnt=%0d v=%b",
                         cyc, count, busy, can_issue, wb_valid, q.size(), exp_valid);
            end
            if (exp_valid) begin
                exp_data = !q[0].ld ? 32'h0 : (exp_byp ? d : q[0].data);
                checks++;
                if ({wb_we, wb_rd, wb_pc, wb_data} !== {q[0].ld, q[0].rd, q[0].pc, exp_data}) begin
                    errors++;
                    $display("FAIL rand_wb cyc %0d: got we=%b rd=%0d pc=%h d=%h exp %b %0d %h %h",
                             cyc, wb_we, wb_rd, wb_pc, wb_data, q[0].ld, q[0].rd, q[0].pc,
                             exp_data);
                end
            end

            do_retire = (exp_valid && rdy) || (head_done && q[0].killed);
            if (ok) begin
                q[ndone].data = d;
                ndone++;
            end
            if (fl) begin
                foreach (q[i]) q[i].killed = 1'b1;
            end
            if (do_retire) begin
                void'(q.pop_front());
                ndone--;
            end
            if (fire) begin
                q.push_back('{ld: ld, rd: rd, pc: pc, data: 32'h0, killed: fl});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_full_wrap();
        test_backpressure();
        test_flush();
        test_store();
        test_bypass();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
